// File: rtl/uart_tx_fsm_pkg.sv
// Shared definitions for the UART transmit path: state codes, line-mux selects,
// payload width and the parity helper.
package uart_tx_fsm_pkg;

    // The Serializer bit counter is 3 bits wide, so the payload width cannot change.
    localparam int DATA_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    typedef enum logic [1:0] {
        SEL_START = 2'd0,
        SEL_STOP  = 2'd1,
        SEL_DATA  = 2'd2,
        SEL_PAR   = 2'd3
    } tx_sel_e;

    // Even parity is the XOR of the payload. Odd parity is the inverse of it.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fsm_if.sv
// Byte-request and Serializer handshake bundle for the UART transmit controller.
interface uart_tx_fsm_if;
    import uart_tx_fsm_pkg::*;

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  ser_done;
    logic                  ser_data;
    logic                  ser_en;
    logic                  busy;
    logic                  TX_OUT;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        input  ser_en, busy, TX_OUT
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, ser_done, ser_data,
        output ser_en, busy, TX_OUT
    );

endinterface

// File: rtl/uart_tx_mux.sv
// Registered line driver: selects the start, stop, data or parity level for TX_OUT.
module uart_tx_mux
    import uart_tx_fsm_pkg::*;
(
    input  logic    CLK,
    input  logic    RST,
    input  tx_sel_e sel,
    input  logic    ser_data,
    input  logic    par_bit,
    output logic    tx_out
);

    // NOTE: state registers use non-blocking assignments under an async reset, so every
    // flop samples the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_out <= 1'b1;
        end else begin
            case (sel)
                SEL_START: tx_out <= 1'b0;
                SEL_STOP:  tx_out <= 1'b1;
                SEL_DATA:  tx_out <= ser_data;
                SEL_PAR:   tx_out <= par_bit;
                default:   tx_out <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit controller: frame sequencing, parity latch, busy flag and the
// Serializer enable. The line level comes from the registered uart_tx_mux.
module uart_tx_fsm
    import uart_tx_fsm_pkg::*;
(
    input  logic         CLK,
    input  logic         RST,
    uart_tx_fsm_if.slave bus
);

    tx_state_e state;
    tx_state_e next_state;
    tx_sel_e   sel;
    logic      busy_q;
    logic      par_en_q;
    logic      par_bit;
    logic      tx_out;

    // NOTE: every combinational output gets a default before the case, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (bus.Data_Valid) next_state = ST_START;
            ST_START:  next_state = ST_DATA;
            ST_DATA:   if (bus.ser_done) next_state = par_en_q ? ST_PARITY : ST_STOP;
            ST_PARITY: next_state = ST_STOP;
            ST_STOP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Requests are taken only in IDLE, which is exactly the busy=0 window. Configuration
    // and parity are frozen at that edge, so changes during a frame have no effect.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= ST_IDLE;
            busy_q   <= 1'b0;
            par_en_q <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != ST_IDLE);
            if (state == ST_IDLE && bus.Data_Valid) begin
                par_en_q <= bus.PAR_EN;
                par_bit  <= calc_parity(bus.P_DATA, bus.PAR_TYP);
            end
        end
    end

    always_comb begin
        sel = SEL_STOP;
        case (state)
            ST_START:  sel = SEL_START;
            ST_DATA:   sel = SEL_DATA;
            ST_PARITY: sel = SEL_PAR;
            default:   sel = SEL_STOP;
        endcase
    end

    uart_tx_mux u_mux (
        .CLK      (CLK),
        .RST      (RST),
        .sel      (sel),
        .ser_data (bus.ser_data),
        .par_bit  (par_bit),
        .tx_out   (tx_out)
    );

    assign bus.ser_en = (state == ST_DATA);
    assign bus.busy   = busy_q;
    assign bus.TX_OUT = tx_out;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm. A small Serializer model closes the ser_en/ser_done loop.
module tb_uart_tx_fsm;
    import uart_tx_fsm_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    uart_tx_fsm_if bus();

    uart_tx_fsm dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Serializer: loads on an accepted request, shifts LSB first while enabled, and
    // clears its counter whenever the enable is low.
    logic [7:0] ser_v;
    logic [2:0] ser_cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ser_v   <= '0;
            ser_cnt <= '0;
        end else if (bus.Data_Valid && !bus.busy) begin
            ser_v   <= bus.P_DATA;
            ser_cnt <= '0;
        end else if (bus.ser_en) begin
            ser_v   <= {1'b0, ser_v[7:1]};
            ser_cnt <= ser_cnt + 3'd1;
        end else begin
            ser_cnt <= '0;
        end
    end
    assign bus.ser_data = ser_v[0];
    assign bus.ser_done = bus.ser_en && (ser_cnt == 3'd7);

    // Capture of one frame: cap_tx[i] is TX_OUT sampled i cycles after the acceptance edge.
    logic [11:0] cap_tx;
    int          cap_busy;
    int          cap_en;

    task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic inj);
        int n;
        n = pen ? 11 : 10;
        cap_tx   = '0;
        cap_busy = 0;
        cap_en   = 0;
        bus.P_DATA     = d;
        bus.PAR_EN     = pen;
        bus.PAR_TYP    = ptyp;
        bus.Data_Valid = 1'b1;
        for (int i = 0; i <= n; i++) begin
            @(negedge CLK);
            cap_tx[i] = bus.TX_OUT;
            cap_busy += int'(bus.busy);
            cap_en   += int'(bus.ser_en);
            if (i == 0) begin
                bus.Data_Valid = 1'b0;
                bus.PAR_EN     = ~pen;
                bus.PAR_TYP    = ~ptyp;
                bus.P_DATA     = ~d;
            end
            if (inj && i == 4) begin
                bus.P_DATA     = 8'hFF;
                bus.Data_Valid = 1'b1;
            end
            if (inj && i == 5) bus.Data_Valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.P_DATA = '0; bus.Data_Valid = 1'b0; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0;
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            checks++;
            if ({bus.TX_OUT, bus.busy, bus.ser_en} !== 3'b100) begin
                errors++;
                $display("FAIL reset_held: tx/busy/en=%b expected 100",
                         {bus.TX_OUT, bus.busy, bus.ser_en});
            end
        end
        RST = 1'b1;
        repeat (20) begin
            @(negedge CLK);
            checks++;
            if ({bus.TX_OUT, bus.busy, bus.ser_en} !== 3'b100) begin
                errors++;
                $display("FAIL reset_idle: tx/busy/en=%b expected 100",
                         {bus.TX_OUT, bus.busy, bus.ser_en});
            end
        end
    endtask

    task automatic test_no_parity();
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cap_tx !== {1'b0, 1'b1, 8'hA5, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL a5_line: got %b expected %b", cap_tx, {1'b0, 1'b1, 8'hA5, 1'b0, 1'b1});
        end
        checks++;
        if (cap_busy !== 10) begin
            errors++;
            $display("FAIL a5_busy_len: got %0d expected 10", cap_busy);
        end
        checks++;
        if (cap_en !== 8) begin
            errors++;
            $display("FAIL a5_ser_en_len: got %0d expected 8", cap_en);
        end
    endtask

    task automatic test_parity();
        @(negedge CLK);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        checks++;
        if (cap_tx !== {1'b1, 1'b0, 8'h0F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL 0f_even_line: got %b expected %b", cap_tx, {1'b1, 1'b0, 8'h0F, 1'b0, 1'b1});
        end
        checks++;
        if (cap_busy !== 11) begin
            errors++;
            $display("FAIL 0f_even_busy_len: got %0d expected 11", cap_busy);
        end
        @(negedge CLK);
        send_frame(8'h0F, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cap_tx !== {1'b1, 1'b1, 8'h0F, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL 0f_odd_line: got %b expected %b", cap_tx, {1'b1, 1'b1, 8'h0F, 1'b0, 1'b1});
        end
        checks++;
        if (cap_busy !== 11) begin
            errors++;
            $display("FAIL 0f_odd_busy_len: got %0d expected 11", cap_busy);
        end
    endtask

    task automatic test_drop_while_busy();
        @(negedge CLK);
        send_frame(8'h01, 1'b1, 1'b0, 1'b1);
        checks++;
        if (cap_tx !== {1'b1, 1'b1, 8'h01, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL drop_01_line: got %b expected %b", cap_tx, {1'b1, 1'b1, 8'h01, 1'b0, 1'b1});
        end
        repeat (4) begin
            @(negedge CLK);
            checks++;
            if ({bus.TX_OUT, bus.busy} !== 2'b10) begin
                errors++;
                $display("FAIL drop_no_ff_frame: tx/busy=%b expected 10", {bus.TX_OUT, bus.busy});
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        @(negedge CLK);
        bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
        @(negedge CLK);
        bus.Data_Valid = 1'b0;
        repeat (3) @(negedge CLK);
        // Three cycles into the frame the line carries D1 of 8'h3C, which is 0.
        checks++;
        if ({bus.TX_OUT, bus.busy, bus.ser_en} !== 3'b011) begin
            errors++;
            $display("FAIL rst_pre: tx/busy/en=%b expected 011", {bus.TX_OUT, bus.busy, bus.ser_en});
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if ({bus.TX_OUT, bus.busy, bus.ser_en} !== 3'b100) begin
            errors++;
            $display("FAIL rst_abort: tx/busy/en=%b expected 100", {bus.TX_OUT, bus.busy, bus.ser_en});
        end
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        send_frame(8'hC3, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cap_tx !== {1'b0, 1'b1, 8'hC3, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL rst_c3_line: got %b expected %b", cap_tx, {1'b0, 1'b1, 8'hC3, 1'b0, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
        checks++;
        if (cap_en !== 8) begin
            errors++;
            $display("FAIL b2b_first_ser_en: got %0d expected 8", cap_en);
        end
        // Issued on the first IDLE cycle; sample 0 is the single idle-high cycle.
        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        checks++;
        if (cap_tx !== {1'b1, 1'b1, 8'h5A, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second_line: got %b expected %b", cap_tx, {1'b1, 1'b1, 8'h5A, 1'b0, 1'b1});
        end
        checks++;
        if (cap_en !== 8) begin
            errors++;
            $display("FAIL b2b_second_ser_en: got %0d expected 8", cap_en);
        end
        checks++;
        if (cap_busy !== 11) begin
            errors++;
            $display("FAIL b2b_second_busy_len: got %0d expected 11", cap_busy);
        end
    endtask

    initial begin
        test_reset();
        test_no_parity();
        test_parity();
        test_drop_while_busy();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (2) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
